proc_clock_ctrl: RTL and testbench
==================================

PROC_CLOCK_CTRL -- requirements
Module: proc_clock_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, sets the width of the divider counter and the cycle counter.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 speed  input  5  divider exponent; half-period = 2^speed + 1 clk cycles.
REQ-005 mode  input  2  operating mode: 00 HALT, 01 RUN, 10 STEP, 11 reserved (treated as HALT).
REQ-006 step_btn  input  1  debounced step level; a rising edge requests one processor cycle.
REQ-007 halt_req  input  1  processor-side stop request, level-sensitive.
REQ-008 proc_clk  output  1  generated processor clock, square wave.
REQ-009 tick  output  1  one-clk pulse coincident with each proc_clk 0->1 transition.
REQ-010 running  output  1  high while in RUN_HI or RUN_LO.
REQ-011 cycle_count  output  CNT_W  count of proc_clk rising edges.

Function
REQ-012 Divider: counter increments each clk; when counter >= (1 << speed), it clears to 0 and raises a one-clk half-period event (hp_ev).
REQ-013 speed is used combinationally; lowering speed below the current counter value produces hp_ev on the next clk.
REQ-014 FSM states: WAIT, HALTED, RUN_LO, RUN_HI, STEP_HI, STEP_LO.
REQ-015 WAIT: the first hp_ev after reset causes no toggle and moves to RUN_LO if mode==01 and halt_req==0, otherwise to HALTED.
REQ-016 HALTED: proc_clk=0; on hp_ev with mode==01 and halt_req==0, go to RUN_LO.
REQ-017 RUN_LO: on hp_ev, if mode==01 and halt_req==0, set proc_clk=1, pulse tick, and go to RUN_HI; otherwise go to HALTED with no edge.
REQ-018 RUN_HI: on hp_ev, set proc_clk=0, then go to RUN_LO; leaving RUN always completes the high phase, and proc_clk is never truncated.
REQ-019 STEP: a step_btn rising edge (against a registered previous value) seen in HALTED with mode==10 sets step_pend.
REQ-020 With step_pend set, the next hp_ev sets proc_clk=1, pulses tick, clears step_pend, and enters STEP_HI.
REQ-021 STEP_HI: on hp_ev, proc_clk=0 and enter STEP_LO; STEP_LO: on hp_ev, enter HALTED.
REQ-022 Step edges outside HALTED are dropped; there is no queueing, and at most one pending step exists.
REQ-023 halt_req and mode changes take effect only at hp_ev boundaries.
REQ-024 cycle_count increments by 1 on each tick and wraps from 2^CNT_W-1 to 0.

Reset
REQ-025 On rst==0, immediately: proc_clk=0, tick=0, running=0, cycle_count=0, counter=0, step_pend=0, step_prev=0, state=WAIT.
REQ-026 Reset asserted mid-high-phase forces proc_clk low asynchronously; no tick follows reset until WAIT completes.

Configuration
REQ-027 Macro CLK_CTRL_CYCLE_COUNT_EN defined: cycle_count is implemented per REQ-024.
REQ-028 Macro CLK_CTRL_CYCLE_COUNT_EN undefined: no counter register exists, and cycle_count is tied to 0.

Structure
REQ-029 Package proc_clk_pkg holds the FSM state enum, the mode encodings (MODE_HALT, MODE_RUN, MODE_STEP), and the SPEED_W=5 constant.
REQ-030 Sub-module half_period_timer contains the REQ-012/013 divider (inputs clk, rst, speed; output hp_ev); the FSM stays in proc_clock_ctrl.

Verification
REQ-031 speed=0, mode=01 from reset: first hp_ev at clk 2 does not toggle; proc_clk then toggles every 2 clks (period 4); tick fires once per period.
REQ-032 speed=3, mode=01: proc_clk high 9 clks, low 9 clks; after 10 rising edges, cycle_count=10.
REQ-033 Run, then drop mode to 00 while proc_clk=1: high phase completes its full 9 clks, then HALTED with proc_clk=0 and running=0.
REQ-034 mode=10, HALTED, speed=1: one step_btn pulse gives exactly one proc_clk high of 3 clks and one tick; a second pulse during STEP_HI gives no extra cycle.
REQ-035 Assert rst low during RUN_HI: proc_clk=0 and cycle_count=0 in the same cycle; after release, the WAIT half-period passes with no toggle.
REQ-036 CNT_W=4, macro defined: 16 ticks wrap cycle_count to 0; with the macro undefined, cycle_count stays 0 throughout.

Source files
------------

// File: rtl/proc_clk_pkg.sv
// Shared types and constants for the processor clock controller: FSM states,
// operating-mode encodings and the divider exponent width.
package proc_clk_pkg;

  localparam int SPEED_W = 5;

  // Encoding 2'b11 is reserved and behaves like MODE_HALT.
  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_HALTED,
    ST_RUN_LO,
    ST_RUN_HI,
    ST_STEP_HI,
    ST_STEP_LO
  } state_e;

endpackage

// File: rtl/half_period_timer.sv
// Programmable divider: hp_ev is high for one clk every 2^speed + 1 clks.
// speed is used live, so lowering it below the running count fires at once.
module half_period_timer
  import proc_clk_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  output logic               hp_ev
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   limit;

  // One extra bit keeps 1 << speed representable when speed equals CNT_W.
  assign limit = (CNT_W + 1)'(1) << speed;
  assign hp_ev = {1'b0, count} >= limit;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (hp_ev) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/proc_clock_ctrl.sv
// Processor clock generator with HALT / RUN / single-STEP modes.
// Define CLK_CTRL_CYCLE_COUNT_EN to implement the cycle_count register.
module proc_clock_ctrl
  import proc_clk_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] speed,
  input  logic [1:0]         mode,
  input  logic               step_btn,
  input  logic               halt_req,
  output logic               proc_clk,
  output logic               tick,
  output logic               running,
  output logic [CNT_W-1:0]   cycle_count
);

  state_e state;
  logic   hp_ev;
  logic   step_prev;
  logic   step_pend;
  logic   run_ok;
  logic   step_edge;
  logic   rise;

  half_period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .speed (speed),
    .hp_ev (hp_ev)
  );

  assign run_ok    = (mode == MODE_RUN) && !halt_req;
  assign step_edge = step_btn && !step_prev;

  // Single source for every proc_clk 0->1 edge; drives both tick and the counter.
  assign rise = hp_ev && (((state == ST_RUN_LO) && run_ok) ||
                          ((state == ST_HALTED) && !run_ok && step_pend));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_WAIT;
      proc_clk  <= 1'b0;
      tick      <= 1'b0;
      running   <= 1'b0;
      step_prev <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_prev <= step_btn;
      tick      <= rise;
      case (state)
        // First half-period after reset only aligns the divider; no edge.
        ST_WAIT: begin
          if (hp_ev) begin
            state   <= run_ok ? ST_RUN_LO : ST_HALTED;
            running <= run_ok;
          end
        end
        ST_HALTED: begin
          if (hp_ev && run_ok) begin
            state     <= ST_RUN_LO;
            running   <= 1'b1;
            step_pend <= 1'b0;
          end else if (rise) begin
            state     <= ST_STEP_HI;
            proc_clk  <= 1'b1;
            step_pend <= 1'b0;
          end else if (step_edge && (mode == MODE_STEP)) begin
            step_pend <= 1'b1;
          end
        end
        ST_RUN_LO: begin
          if (rise) begin
            state    <= ST_RUN_HI;
            proc_clk <= 1'b1;
          end else if (hp_ev) begin
            state   <= ST_HALTED;
            running <= 1'b0;
          end
        end
        // The high phase always runs to completion, whatever mode does.
        ST_RUN_HI: begin
          if (hp_ev) begin
            state    <= ST_RUN_LO;
            proc_clk <= 1'b0;
          end
        end
        ST_STEP_HI: begin
          if (hp_ev) begin
            state    <= ST_STEP_LO;
            proc_clk <= 1'b0;
          end
        end
        ST_STEP_LO: begin
          if (hp_ev) begin
            state <= ST_HALTED;
          end
        end
        default: begin
          state    <= ST_HALTED;
          proc_clk <= 1'b0;
          running  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_CTRL_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count <= '0;
    end else if (rise) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_proc_clock_ctrl.sv
// Directed bench for proc_clock_ctrl: expected tick cycles and counts are queued
// as each scenario is driven and popped whenever the DUT raises tick.
module tb_proc_clock_ctrl;

  localparam int CNT_W = 4;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] cc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       speed = '0;
  logic [1:0]       mode = 2'b00;
  logic             step_btn = 1'b0;
  logic             halt_req = 1'b0;
  logic             proc_clk;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] cycle_count;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  proc_clock_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .speed       (speed),
    .mode        (mode),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .proc_clk    (proc_clk),
    .tick        (tick),
    .running     (running),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cc_exp(input int n);
`ifdef CLK_CTRL_CYCLE_COUNT_EN
    return CNT_W'(n);
`else
    return '0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int n);
    exp_t e;
    e.cyc = c;
    e.cc  = cc_exp(n);
    sb.push_back(e);
  endtask

  // One clk; outputs sampled on the falling edge, ticks matched to the queue.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (tick === 1'b1) begin
      if (sb.size() == 0) begin
        check("tick_unexpected", 32'(tick), 32'd0);
      end else begin
        e = sb.pop_front();
        check("tick_cycle", 32'(cyc), 32'(e.cyc));
        check("tick_count", 32'(cycle_count), 32'(e.cc));
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) cycle();
  endtask

  task automatic do_reset(input logic [4:0] sp, input logic [1:0] md);
    @(negedge clk);
    rst      = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    speed    = sp;
    mode     = md;
    #1;
    check("rst_proc_clk", 32'(proc_clk), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;

    // Fastest run: WAIT ends at clk 2, then period 4 with rising edges at 4k.
    do_reset(5'd0, 2'b01);
    for (int k = 1; k <= 4; k++) push(4 * k, k);
    run_to(3);
    check("s0_wait_low", 32'(proc_clk), 32'd0);
    check("s0_running", 32'(running), 32'd1);
    run_to(4);
    check("s0_first_high", 32'(proc_clk), 32'd1);
    run_to(6);
    check("s0_low_again", 32'(proc_clk), 32'd0);
    run_to(17);
    check("s0_all_ticks", 32'(sb.size()), 32'd0);

    // speed 3: 9-clk half periods, rising edges at 18 + 18k.
    do_reset(5'd3, 2'b01);
    for (int k = 0; k < 10; k++) push(18 + 18 * k, k + 1);
    run_to(26);
    check("s3_high_9", 32'(proc_clk), 32'd1);
    run_to(27);
    check("s3_fall", 32'(proc_clk), 32'd0);
    run_to(181);
    check("s3_count_10", 32'(cycle_count), 32'(cc_exp(10)));
    check("s3_all_ticks", 32'(sb.size()), 32'd0);

    // Drop to HALT mid-high-phase: high completes at 189, halted from 198.
    mode = 2'b00;
    run_to(188);
    check("halt_high_kept", 32'(proc_clk), 32'd1);
    run_to(189);
    check("halt_fall", 32'(proc_clk), 32'd0);
    check("halt_still_run_lo", 32'(running), 32'd1);
    run_to(198);
    check("halt_running", 32'(running), 32'd0);
    check("halt_proc_clk", 32'(proc_clk), 32'd0);

    // Single step at speed 1 (events at 201 + 3k); second press in STEP_HI dropped.
    speed = 5'd1;
    mode  = 2'b10;
    run_to(202);
    step_btn = 1'b1;
    run_to(203);
    step_btn = 1'b0;
    push(204, 11);
    run_to(205);
    step_btn = 1'b1;
    check("step_high_a", 32'(proc_clk), 32'd1);
    run_to(206);
    step_btn = 1'b0;
    check("step_high_b", 32'(proc_clk), 32'd1);
    run_to(207);
    check("step_fall", 32'(proc_clk), 32'd0);
    run_to(220);
    check("step_running", 32'(running), 32'd0);
    check("step_one_tick", 32'(sb.size()), 32'd0);
    check("step_count", 32'(cycle_count), 32'(cc_exp(11)));

    // Back to RUN, then asynchronous reset while proc_clk is high.
    mode = 2'b01;
    push(225, 12);
    run_to(226);
    check("arst_pre_high", 32'(proc_clk), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_proc_clk", 32'(proc_clk), 32'd0);
    check("arst_count", 32'(cycle_count), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    push(6, 1);
    push(12, 2);
    run_to(5);
    check("arst_wait_no_toggle", 32'(proc_clk), 32'd0);
    check("arst_run_lo", 32'(running), 32'd1);
    run_to(13);
    check("arst_ticks", 32'(sb.size()), 32'd0);

    // 4-bit counter wraps on the 16th rising edge; then halt_req stops the run.
    do_reset(5'd0, 2'b01);
    for (int k = 1; k <= 17; k++) push(4 * k, k);
    run_to(63);
    check("wrap_pre", 32'(cycle_count), 32'(cc_exp(15)));
    run_to(69);
    check("wrap_ticks", 32'(sb.size()), 32'd0);
    halt_req = 1'b1;
    run_to(72);
    check("hreq_running", 32'(running), 32'd0);
    run_to(80);
    check("hreq_proc_clk", 32'(proc_clk), 32'd0);
    check("hreq_count", 32'(cycle_count), 32'(cc_exp(17)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
